// File: rtl/mem_bus_arbiter.sv
// ---------------------------------------------------------------------------
// mem_bus_arbiter
//
// Shares the single external memory bus between the instruction fetch port
// and the MEM-stage data port. One transaction is in flight at a time; every
// bus output is a register, and each requester gets a one-cycle ack pulse
// when its transaction completes.
//
// Arbitration: data has priority, but once MAX_DATA_RUN data grants have been
// made back to back while a fetch was waiting, the fetch wins the next grant.
//
// Optional feature (compile-time macro ARB_TIMEOUT_EN):
//   defined   - a BUSY transaction with no bus_ack for TIMEOUT_CYCLES cycles
//               is aborted; the owner gets ack + err with rdata = 0.
//   undefined - BUSY waits for bus_ack indefinitely; inst_err/data_err are 0.
//
// Ports
//   clk, rst                 clock (rising edge), async active-low reset
//   inst_req/inst_addr       fetch request, held until inst_ack
//   inst_ack/inst_rdata/inst_err   fetch completion pulse, data, abort flag
//   data_req/data_we/data_be/data_addr/data_wdata   data request
//   data_ack/data_rdata/data_err   data completion pulse, data, abort flag
//   bus_req/bus_we/bus_be/bus_addr/bus_wdata        registered bus request
//   bus_ack/bus_rdata        external completion and read data
// ---------------------------------------------------------------------------
module mem_bus_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int MAX_DATA_RUN   = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                rst,

  input  logic                inst_req,
  input  logic [ADDR_W-1:0]   inst_addr,
  output logic                inst_ack,
  output logic [DATA_W-1:0]   inst_rdata,
  output logic                inst_err,

  input  logic                data_req,
  input  logic                data_we,
  input  logic [DATA_W/8-1:0] data_be,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic                data_ack,
  output logic [DATA_W-1:0]   data_rdata,
  output logic                data_err,

  output logic                bus_req,
  output logic                bus_we,
  output logic [DATA_W/8-1:0] bus_be,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [DATA_W-1:0]   bus_wdata,
  input  logic                bus_ack,
  input  logic [DATA_W-1:0]   bus_rdata
);

  localparam int BE_W  = DATA_W / 8;
  localparam int RUN_W = $clog2(MAX_DATA_RUN + 1);
  localparam logic [RUN_W-1:0] RUN_LIMIT = RUN_W'(MAX_DATA_RUN);

  // Elaboration-time parameter sanity checks.
  if (MAX_DATA_RUN < 1) begin : g_bad_run
    $error("mem_bus_arbiter: MAX_DATA_RUN must be >= 1");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("mem_bus_arbiter: TIMEOUT_CYCLES must be >= 1");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_reg;
  logic             owner_inst_reg;   // 1: fetch owns the bus, 0: data owns it
  logic [RUN_W-1:0] run_reg;          // data grants made while a fetch waited

  // Fetch wins only when data is idle or the data run has hit its limit.
  logic inst_win;
  assign inst_win = inst_req && (!data_req || (run_reg == RUN_LIMIT));

`ifdef ARB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] busy_cnt_reg;
  logic            timeout_hit;

  // busy_cnt_reg counts BUSY cycles already spent without bus_ack; the abort
  // fires at the edge ending the TIMEOUT_CYCLES-th such cycle.
  assign timeout_hit = (busy_cnt_reg == TO_LAST);
`else
  assign inst_err = 1'b0;
  assign data_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= ST_IDLE;
      owner_inst_reg <= 1'b0;
      run_reg        <= '0;
      inst_ack       <= 1'b0;
      inst_rdata     <= '0;
      data_ack       <= 1'b0;
      data_rdata     <= '0;
      bus_req        <= 1'b0;
      bus_we         <= 1'b0;
      bus_be         <= '0;
      bus_addr       <= '0;
      bus_wdata      <= '0;
`ifdef ARB_TIMEOUT_EN
      busy_cnt_reg   <= '0;
      inst_err       <= 1'b0;
      data_err       <= 1'b0;
`endif
    end else begin
      // Acks and errors are single-cycle pulses; they are only raised on the
      // edge entering DONE, so default them low every cycle.
      inst_ack <= 1'b0;
      data_ack <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      inst_err <= 1'b0;
      data_err <= 1'b0;
`endif

      case (state_reg)
        ST_IDLE: begin
          // The run counter only tracks back-to-back data grants with a
          // fetch waiting; any idle cycle without a fetch pending resets it.
          if (!inst_req || inst_win) begin
            run_reg <= '0;
          end else if (data_req) begin
            run_reg <= run_reg + 1'b1;
          end

          if (inst_req || data_req) begin
            state_reg      <= ST_BUSY;
            owner_inst_reg <= inst_win;
            bus_req        <= 1'b1;
`ifdef ARB_TIMEOUT_EN
            busy_cnt_reg   <= '0;
`endif
            if (inst_win) begin
              // A fetch is always a full-word read.
              bus_addr  <= inst_addr;
              bus_we    <= 1'b0;
              bus_be    <= {BE_W{1'b1}};
              bus_wdata <= '0;
            end else begin
              bus_addr  <= data_addr;
              bus_we    <= data_we;
              bus_be    <= data_be;
              bus_wdata <= data_wdata;
            end
          end
        end

        ST_BUSY: begin
          // bus_* stay untouched here so the slave sees a stable request.
          if (bus_ack) begin
            bus_req   <= 1'b0;
            state_reg <= ST_DONE;
            if (owner_inst_reg) begin
              inst_ack   <= 1'b1;
              inst_rdata <= bus_rdata;
            end else begin
              data_ack   <= 1'b1;
              data_rdata <= bus_rdata;
            end
          end
`ifdef ARB_TIMEOUT_EN
          else if (timeout_hit) begin
            bus_req   <= 1'b0;
            state_reg <= ST_DONE;
            if (owner_inst_reg) begin
              inst_ack   <= 1'b1;
              inst_err   <= 1'b1;
              inst_rdata <= '0;
            end else begin
              data_ack   <= 1'b1;
              data_err   <= 1'b1;
              data_rdata <= '0;
            end
          end else begin
            busy_cnt_reg <= busy_cnt_reg + 1'b1;
          end
`endif
        end

        ST_DONE: begin
          // Ack is visible this cycle; the requester drops its request by
          // the next edge, so the following IDLE cycle sees fresh requests.
          state_reg <= ST_IDLE;
        end

        default: begin
          state_reg <= ST_IDLE;
          bus_req   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_bus_arbiter
//
// Directed scenarios (single fetch, simultaneous requests, data run limit,
// long bus wait, timeout or indefinite wait, reset mid-transaction) followed
// by a randomized run checked against a transaction-level reference model.
// ---------------------------------------------------------------------------
module tb_mem_bus_arbiter;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int BE_W    = DATA_W / 8;
  localparam int MAX_RUN = 4;
  localparam int TO_CYC  = 8;

  logic              clk;
  logic              rst;
  logic              inst_req;
  logic [ADDR_W-1:0] inst_addr;
  logic              inst_ack;
  logic [DATA_W-1:0] inst_rdata;
  logic              inst_err;
  logic              data_req;
  logic              data_we;
  logic [BE_W-1:0]   data_be;
  logic [ADDR_W-1:0] data_addr;
  logic [DATA_W-1:0] data_wdata;
  logic              data_ack;
  logic [DATA_W-1:0] data_rdata;
  logic              data_err;
  logic              bus_req;
  logic              bus_we;
  logic [BE_W-1:0]   bus_be;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic              bus_ack;
  logic [DATA_W-1:0] bus_rdata;

  int checks;
  int failures;

  mem_bus_arbiter #(
    .ADDR_W        (ADDR_W),
    .DATA_W        (DATA_W),
    .MAX_DATA_RUN  (MAX_RUN),
    .TIMEOUT_CYCLES(TO_CYC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .inst_req  (inst_req),
    .inst_addr (inst_addr),
    .inst_ack  (inst_ack),
    .inst_rdata(inst_rdata),
    .inst_err  (inst_err),
    .data_req  (data_req),
    .data_we   (data_we),
    .data_be   (data_be),
    .data_addr (data_addr),
    .data_wdata(data_wdata),
    .data_ack  (data_ack),
    .data_rdata(data_rdata),
    .data_err  (data_err),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_be    (bus_be),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_ack   (bus_ack),
    .bus_rdata (bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "simulation did not finish");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst        = 1'b0;
    inst_req   = 1'b0;
    inst_addr  = '0;
    data_req   = 1'b0;
    data_we    = 1'b0;
    data_be    = '0;
    data_addr  = '0;
    data_wdata = '0;
    bus_ack    = 1'b0;
    bus_rdata  = '0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    tick();
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_bus_req"},    32'(bus_req),   32'd0);
    check_eq({tag, "_bus_we"},     32'(bus_we),    32'd0);
    check_eq({tag, "_bus_be"},     32'(bus_be),    32'd0);
    check_eq({tag, "_bus_addr"},   bus_addr,       32'd0);
    check_eq({tag, "_bus_wdata"},  bus_wdata,      32'd0);
    check_eq({tag, "_inst_ack"},   32'(inst_ack),  32'd0);
    check_eq({tag, "_data_ack"},   32'(data_ack),  32'd0);
    check_eq({tag, "_inst_rdata"}, inst_rdata,     32'd0);
    check_eq({tag, "_data_rdata"}, data_rdata,     32'd0);
    check_eq({tag, "_inst_err"},   32'(inst_err),  32'd0);
    check_eq({tag, "_data_err"},   32'(data_err),  32'd0);
  endtask

  // Entered in the first cycle bus_req is expected high. bus_ack is driven in
  // the (delay+1)-th BUSY cycle; the owner's ack is checked in the next cycle.
  task automatic do_xfer(input string tag, input bit exp_inst,
                         input logic [31:0] e_addr, input bit e_we,
                         input logic [3:0] e_be, input logic [31:0] e_wd,
                         input int delay, input logic [31:0] rd, input bit hold);
    for (int i = 0; i <= delay; i++) begin
      check_eq({tag, "_bus_req"},  32'(bus_req),  32'd1);
      check_eq({tag, "_bus_addr"}, bus_addr,      e_addr);
      check_eq({tag, "_bus_we"},   32'(bus_we),   32'(e_we));
      if (!exp_inst) begin
        check_eq({tag, "_bus_be"},    32'(bus_be), 32'(e_be));
        check_eq({tag, "_bus_wdata"}, bus_wdata,   e_wd);
      end
      check_eq({tag, "_ack_early"}, 32'({inst_ack, data_ack}), 32'd0);
      if (i == delay) begin
        bus_ack   = 1'b1;
        bus_rdata = rd;
      end
      tick();
    end
    bus_ack   = 1'b0;
    bus_rdata = $urandom;
    check_eq({tag, "_bus_req_off"}, 32'(bus_req),  32'd0);
    check_eq({tag, "_inst_ack"},    32'(inst_ack), 32'(exp_inst));
    check_eq({tag, "_data_ack"},    32'(data_ack), 32'(!exp_inst));
    check_eq({tag, "_rdata"},       exp_inst ? inst_rdata : data_rdata, rd);
    check_eq({tag, "_err"},         32'({inst_err, data_err}), 32'd0);
    $display("xfer %s owner=%s addr=0x%08h rdata=0x%08h", tag, exp_inst ? "inst" : "data", e_addr, rd);
    if (!hold) begin
      if (exp_inst) inst_req = 1'b0;
      else          data_req = 1'b0;
    end
    tick();
    check_eq({tag, "_ack_pulse"},  32'({inst_ack, data_ack}), 32'd0);
    check_eq({tag, "_rdata_hold"}, exp_inst ? inst_rdata : data_rdata, rd);
  endtask

  // Reference model state for the randomized run.
  int           m_phase;      // 0 arbiter free, 1 transaction on bus, 2 ack cycle
  int           m_run;
  bit           m_inst_own;
  logic [31:0]  m_addr, m_wd, m_ird, m_drd;
  logic         m_we;
  logic [3:0]   m_be;
  bit           p_ireq, p_dreq, p_we, p_back, win, e_iack, e_dack;
  logic [31:0]  p_iaddr, p_daddr, p_wd, p_brd;
  logic [3:0]   p_be;
  int           s_cnt;
  bit           s_armed;
  int           n_igrant, n_dgrant;

  task automatic new_inst_req();
    inst_req  = 1'b1;
    inst_addr = $urandom & 32'hFFFF_FFFC;
  endtask

  task automatic new_data_req();
    data_req   = 1'b1;
    data_we    = 1'($urandom);
    data_be    = 4'($urandom);
    data_addr  = $urandom & 32'hFFFF_FFFC;
    data_wdata = $urandom;
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    // Reset state
    apply_reset();
    check_reset_state("reset");

    // 1: single fetch, bus_ack one cycle after bus_req
    inst_req  = 1'b1;
    inst_addr = 32'hbfc0_0000;
    tick();
    do_xfer("t1_fetch", 1'b1, 32'hbfc0_0000, 1'b0, 4'hF, 32'h0, 1, 32'h3c08_bfc0, 1'b0);

    // 2: simultaneous requests, data first then fetch
    inst_req   = 1'b1;
    inst_addr  = 32'hbfc0_0004;
    data_req   = 1'b1;
    data_we    = 1'b1;
    data_be    = 4'b0011;
    data_addr  = 32'h8000_0010;
    data_wdata = 32'h0000_1234;
    tick();
    do_xfer("t2_data", 1'b0, 32'h8000_0010, 1'b1, 4'b0011, 32'h0000_1234, 0, 32'h5555_aaaa, 1'b0);
    tick();
    do_xfer("t2_inst", 1'b1, 32'hbfc0_0004, 1'b0, 4'hF, 32'h0, 2, 32'h2408_0001, 1'b0);

    // 3: both held continuously -> D,D,D,D,I repeating
    inst_req   = 1'b1;
    inst_addr  = 32'hbfc0_0100;
    data_req   = 1'b1;
    data_we    = 1'b0;
    data_be    = 4'hF;
    data_addr  = 32'h8000_0200;
    data_wdata = 32'hdead_beef;
    tick();
    for (int g = 0; g < 10; g++) begin
      if ((g % (MAX_RUN + 1)) == MAX_RUN)
        do_xfer("t3_run_inst", 1'b1, 32'hbfc0_0100, 1'b0, 4'hF, 32'h0, g % 3, 32'h1000 + 32'(g), 1'b1);
      else
        do_xfer("t3_run_data", 1'b0, 32'h8000_0200, 1'b0, 4'hF, 32'hdead_beef, g % 3, 32'h2000 + 32'(g), 1'b1);
      if (g != 9) tick();
    end
    inst_req = 1'b0;
    data_req = 1'b0;
    tick();
    check_eq("t3_idle_after", 32'(bus_req), 32'd0);

    // 4: bus_ack delayed 10 cycles
    data_req   = 1'b1;
    data_we    = 1'b1;
    data_be    = 4'b1100;
    data_addr  = 32'h8000_0300;
    data_wdata = 32'hcafe_f00d;
    tick();
    do_xfer("t4_slow", 1'b0, 32'h8000_0300, 1'b1, 4'b1100, 32'hcafe_f00d, 10, 32'h0bad_0bad, 1'b0);

    // 5: slave never answers
    data_req   = 1'b1;
    data_we    = 1'b0;
    data_be    = 4'hF;
    data_addr  = 32'h8000_0400;
    data_wdata = 32'h0;
    tick();
`ifdef ARB_TIMEOUT_EN
    for (int i = 0; i < TO_CYC; i++) begin
      check_eq("t5_busy_hold", 32'(bus_req), 32'd1);
      tick();
    end
    check_eq("t5_bus_req_drop", 32'(bus_req),  32'd0);
    check_eq("t5_data_ack",     32'(data_ack), 32'd1);
    check_eq("t5_data_err",     32'(data_err), 32'd1);
    check_eq("t5_data_rdata",   data_rdata,    32'd0);
    check_eq("t5_inst_ack",     32'(inst_ack), 32'd0);
    data_req = 1'b0;
    tick();
    check_eq("t5_err_clear", 32'({data_ack, data_err}), 32'd0);
`else
    // No timeout: request stays up far beyond TIMEOUT_CYCLES until answered.
    do_xfer("t5_no_timeout", 1'b0, 32'h8000_0400, 1'b0, 4'hF, 32'h0, 3 * TO_CYC, 32'h7777_0000, 1'b0);
`endif

    // 6: reset in the middle of a transaction
    data_req   = 1'b1;
    data_we    = 1'b0;
    data_addr  = 32'h8000_0500;
    tick();
    check_eq("t6_busy", 32'(bus_req), 32'd1);
    tick();
    #1 rst = 1'b0;
    #1 check_eq("t6_async_drop", 32'(bus_req), 32'd0);
    data_req = 1'b0;
    bus_ack  = 1'b1;    // a late answer must not produce an ack
    @(posedge clk);
    #3 rst = 1'b1;
    bus_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("t6_no_ack", 32'({bus_req, inst_ack, data_ack}), 32'd0);
    end
    inst_req  = 1'b1;
    inst_addr = 32'hbfc0_0200;
    tick();
    do_xfer("t6_after_rst", 1'b1, 32'hbfc0_0200, 1'b0, 4'hF, 32'h0, 0, 32'h0000_0042, 1'b0);

    // Randomized run against the reference model
    apply_reset();
    check_reset_state("rand_reset");
    m_phase = 0; m_run = 0; m_ird = '0; m_drd = '0;
    m_inst_own = 1'b0; m_addr = '0; m_wd = '0; m_we = 1'b0; m_be = '0;
    p_ireq = 1'b0; p_dreq = 1'b0; p_we = 1'b0; p_back = 1'b0;
    p_iaddr = '0; p_daddr = '0; p_wd = '0; p_brd = '0; p_be = '0;
    s_cnt = 0; s_armed = 1'b0; n_igrant = 0; n_dgrant = 0;

    for (int cyc = 0; cyc < 3000; cyc++) begin
      tick();
      e_iack = 1'b0;
      e_dack = 1'b0;
      case (m_phase)
        0: begin
          if (p_ireq || p_dreq) begin
            win = p_ireq && (!p_dreq || m_run == MAX_RUN);
            if (!p_ireq || win) m_run = 0;
            else                m_run = m_run + 1;
            m_inst_own = win;
            if (win) begin
              m_addr = p_iaddr; m_we = 1'b0; m_be = 4'hF; m_wd = '0;
              n_igrant++;
            end else begin
              m_addr = p_daddr; m_we = p_we; m_be = p_be; m_wd = p_wd;
              n_dgrant++;
            end
            m_phase = 1;
          end else begin
            m_run = 0;
          end
        end
        1: begin
          if (p_back) begin
            m_phase = 2;
            if (m_inst_own) begin e_iack = 1'b1; m_ird = p_brd; end
            else            begin e_dack = 1'b1; m_drd = p_brd; end
          end
        end
        default: m_phase = 0;
      endcase

      check_eq("rnd_bus_req",    32'(bus_req),  32'(m_phase == 1));
      check_eq("rnd_inst_ack",   32'(inst_ack), 32'(e_iack));
      check_eq("rnd_data_ack",   32'(data_ack), 32'(e_dack));
      check_eq("rnd_inst_rdata", inst_rdata,    m_ird);
      check_eq("rnd_data_rdata", data_rdata,    m_drd);
      check_eq("rnd_err",        32'({inst_err, data_err}), 32'd0);
      if (m_phase == 1) begin
        check_eq("rnd_bus_addr", bus_addr,    m_addr);
        check_eq("rnd_bus_we",   32'(bus_we), 32'(m_we));
        if (!m_inst_own) begin
          check_eq("rnd_bus_be",    32'(bus_be), 32'(m_be));
          check_eq("rnd_bus_wdata", bus_wdata,   m_wd);
        end
      end
      if (e_iack || e_dack)
        $display("rnd cyc=%0d ack=%s rdata=0x%08h run=%0d", cyc, e_iack ? "inst" : "data",
                 e_iack ? m_ird : m_drd, m_run);

      // Requesters: hold until ack, then maybe issue the next request at once.
      if (e_iack) begin
        if ($urandom_range(0, 1) == 0) new_inst_req();
        else                           inst_req = 1'b0;
      end else if (!inst_req && $urandom_range(0, 3) == 0) begin
        new_inst_req();
      end
      if (e_dack) begin
        if ($urandom_range(0, 3) != 0) new_data_req();
        else                           data_req = 1'b0;
      end else if (!data_req && $urandom_range(0, 1) == 0) begin
        new_data_req();
      end

      // Bus slave: random 0..3 cycle wait; stray acks while idle are ignored.
      if (m_phase == 1) begin
        if (!s_armed) begin
          s_armed = 1'b1;
          s_cnt   = $urandom_range(0, 3);
        end
        if (s_cnt == 0) begin
          bus_ack   = 1'b1;
          bus_rdata = $urandom;
          s_armed   = 1'b0;
        end else begin
          bus_ack = 1'b0;
          s_cnt   = s_cnt - 1;
        end
      end else begin
        bus_ack   = ($urandom_range(0, 7) == 0);
        bus_rdata = $urandom;
      end

      p_ireq  = inst_req;  p_iaddr = inst_addr;
      p_dreq  = data_req;  p_daddr = data_addr;
      p_we    = data_we;   p_be    = data_be;   p_wd = data_wdata;
      p_back  = bus_ack;   p_brd   = bus_rdata;
    end
    $display("rnd grants inst=%0d data=%0d", n_igrant, n_dgrant);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
